// File: rtl/proj_pkg.sv
// Shared types and constants for the projection-unit arbiter slice.
// Box-sanity helper is only called when PROJ_ARB_BOX_CHECK_EN is defined.
package proj_pkg;

    localparam int unsigned FRAC_BITS = 9;
    localparam int unsigned COORD_W   = 16;

    // 3D box in s6c9f fixed point, max corner in the upper half
    typedef struct packed {
        logic signed [COORD_W-1:0] max_z;
        logic signed [COORD_W-1:0] max_y;
        logic signed [COORD_W-1:0] max_x;
        logic signed [COORD_W-1:0] min_z;
        logic signed [COORD_W-1:0] min_y;
        logic signed [COORD_W-1:0] min_x;
    } box3d_t;

    typedef struct packed {
        logic [COORD_W-1:0] ver_max;
        logic [COORD_W-1:0] ver_min;
        logic [COORD_W-1:0] hor_max;
        logic [COORD_W-1:0] hor_min;
    } bbox2d_t;

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    // Degenerate corners or a box entirely behind the sensor
    function automatic logic box_invalid(input box3d_t b);
        return (b.min_x > b.max_x) || (b.min_y > b.max_y) ||
               (b.min_z > b.max_z) || (b.max_x <= 16'sd0);
    endfunction

endpackage

// File: rtl/proj_arbiter_if.sv
// Requester, projector and result handshakes of proj_arbiter.
// master = arbiter view, slave = surrounding environment view.
interface proj_arbiter_if
    import proj_pkg::*;
#(
    parameter int unsigned N_REQ = 2
) ();
    localparam int unsigned SRC_W = $clog2(N_REQ);

    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ-1:0]         req_ready;
    box3d_t [N_REQ-1:0]       req_box;

    logic                     prj_in_valid;
    logic                     prj_in_ready;
    box3d_t                   prj_in_box;

    logic                     prj_out_valid;
    logic                     prj_out_ready;
    bbox2d_t                  prj_out_bbox;

    logic                     res_valid;
    logic                     res_ready;
    bbox2d_t                  res_bbox;
    logic [SRC_W-1:0]         res_src;

    modport master (
        input  req_valid, req_box, prj_in_ready, prj_out_valid, prj_out_bbox, res_ready,
        output req_ready, prj_in_valid, prj_in_box, prj_out_ready, res_valid, res_bbox, res_src
    );

    modport slave (
        output req_valid, req_box, prj_in_ready, prj_out_valid, prj_out_bbox, res_ready,
        input  req_ready, prj_in_valid, prj_in_box, prj_out_ready, res_valid, res_bbox, res_src
    );

endinterface

// File: rtl/proj_tag_fifo.sv
// In-flight source-index FIFO; push/pop are ignored when full/empty.
module proj_tag_fifo #(
    parameter  int unsigned DEPTH = 8,
    parameter  int unsigned WIDTH = 1,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];
    assign count    = count_q;

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/proj_arbiter.sv
// Round-robin sharing of one projector between N_REQ box producers, with source tagging.
// Optional PROJ_ARB_BOX_CHECK_EN drops invalid boxes and adds the drop_cnt port.
module proj_arbiter
    import proj_pkg::*;
#(
    parameter  int unsigned N_REQ     = 2,
    parameter  int unsigned TAG_DEPTH = 8,
    localparam int unsigned SRC_W     = $clog2(N_REQ),
    localparam int unsigned CNT_W     = $clog2(TAG_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    proj_arbiter_if.master     bus,
    output logic [CNT_W-1:0]   inflight,
    output logic               err
`ifdef PROJ_ARB_BOX_CHECK_EN
    ,
    output logic [15:0]        drop_cnt
`endif
);

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic [SRC_W-1:0]  rr_q;
    logic [SRC_W-1:0]  rr_d;
    logic [SRC_W-1:0]  cand;
    logic [SRC_W-1:0]  gnt_idx;
    logic              gnt_any;
    logic              issue_ok;
    logic              push;
    logic [N_REQ-1:0]  req_ready_c;
    box3d_t            gnt_box;
    box3d_t            box_q;

    logic              tag_full;
    logic              tag_empty;
    logic [SRC_W-1:0]  tag_head;

    logic              run_q;
    logic              prj_out_ready_c;
    logic              res_hs;
    logic              res_valid_q;
    bbox2d_t           res_bbox_q;
    logic [SRC_W-1:0]  res_src_q;
    logic              err_q;

`ifdef PROJ_ARB_BOX_CHECK_EN
    logic              drop;
    logic [15:0]       drop_cnt_q;
`endif

    // First valid requester at or after the priority pointer
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = SRC_W'((32'(rr_q) + i) % N_REQ);
            if (!gnt_any && bus.req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign gnt_box  = bus.req_box[gnt_idx];
    assign issue_ok = gnt_any && !tag_full && ((state_q == ARB) || bus.prj_in_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        req_ready_c = '0;
        push        = 1'b0;
`ifdef PROJ_ARB_BOX_CHECK_EN
        drop        = 1'b0;
`endif
        if (state_q == HOLD && bus.prj_in_ready) begin
            state_d = ARB;
        end
        if (issue_ok) begin
            req_ready_c[gnt_idx] = 1'b1;
            rr_d = (gnt_idx == SRC_W'(N_REQ - 1)) ? '0 : gnt_idx + SRC_W'(1);
`ifdef PROJ_ARB_BOX_CHECK_EN
            if (box_invalid(gnt_box)) begin
                drop = 1'b1;
            end else begin
                push    = 1'b1;
                state_d = HOLD;
            end
`else
            push    = 1'b1;
            state_d = HOLD;
`endif
        end
    end

    proj_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .WIDTH (SRC_W)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (gnt_idx),
        .pop       (res_hs),
        .pop_data  (tag_head),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (inflight)
    );

    // run_q keeps prj_out_ready low while reset is asserted
    assign prj_out_ready_c = run_q && (!res_valid_q || bus.res_ready);
    assign res_hs          = bus.prj_out_valid && prj_out_ready_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            box_q       <= '0;
            run_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_bbox_q  <= '0;
            res_src_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (push) begin
                box_q <= gnt_box;
            end
            if (res_hs) begin
                res_valid_q <= 1'b1;
                res_bbox_q  <= bus.prj_out_bbox;
                res_src_q   <= tag_empty ? '0 : tag_head;
            end else if (bus.res_ready) begin
                res_valid_q <= 1'b0;
            end
            if (res_hs && tag_empty) begin
                err_q <= 1'b1;
            end
        end
    end

`ifdef PROJ_ARB_BOX_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    assign bus.req_ready     = req_ready_c;
    assign bus.prj_in_valid  = (state_q == HOLD);
    assign bus.prj_in_box    = box_q;
    assign bus.prj_out_ready = prj_out_ready_c;
    assign bus.res_valid     = res_valid_q;
    assign bus.res_bbox      = res_bbox_q;
    assign bus.res_src       = res_src_q;
    assign err               = err_q;

endmodule

// File: doc/proj_arbiter.md
# proj_arbiter

Round-robin scheduler that shares one `project2image` projection unit between `N_REQ` 3D bounding-box producers (LiDAR cluster extractors). It sits between the clustering stage and the projector. It grants one box per handshake and registers it into the projector input. It tags each issued box with its source index in an in-flight FIFO, and returns each projected 64-bit `bbox` together with the source index of the box it came from.

## Interface
- `N_REQ`, 2: number of requesters, 2..8.
- `TAG_DEPTH`, 8: maximum boxes in flight inside the projector; power of two.
- `SRC_W`, `$clog2(N_REQ)`: width of the source index.

- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `req_valid` in N_REQ: per-requester box valid.
- `req_ready` out N_REQ: per-requester accept; at most one bit high.
- `req_box` in N_REQ*96: per-requester `{max_z,max_y,max_x,min_z,min_y,min_x}`, each signed 16-bit s6c9f.
- `prj_in_valid` out 1: box valid toward the projector.
- `prj_in_ready` in 1: projector accepts the box.
- `prj_in_box` out 96: registered granted box.
- `prj_out_valid` in 1: projector result valid.
- `prj_out_ready` out 1: result accept toward the projector.
- `prj_out_bbox` in 64: projected `{VerMax,VerMin,HorMax,HorMin}`, each zero-extended to 16 bits.
- `res_valid` out 1: tagged result valid.
- `res_ready` in 1: downstream accept.
- `res_bbox` out 64: registered result.
- `res_src` out SRC_W: requester that produced the result.
- `inflight` out $clog2(TAG_DEPTH)+1: number of boxes issued and not yet returned.
- `err` out 1: sticky protocol error.

## Operation
- Arbiter FSM, two states:
  - ARB: pick the first valid requester at or after priority pointer `rr`.
  - HOLD: a box sits in the `prj_in` register waiting for `prj_in_ready`.
- ARB → HOLD:
  - Condition: some `req_valid` is high, the input register is empty, and the tag FIFO is not full.
  - `req_ready[g]` is high combinationally for the granted requester `g` only.
  - The box is captured and `g` is pushed into the tag FIFO on that same edge.
  - `rr` becomes `(g+1) mod N_REQ`.
- HOLD → ARB when `prj_in_valid && prj_in_ready`.
- HOLD → HOLD: back-to-back issue is allowed in the accept cycle if the ARB conditions also hold.
- Full tag FIFO blocks the grant, even if a pop happens in the same cycle. No push/pop bypass when full.
- `prj_out_ready = !res_valid || res_ready`.
- On `prj_out_valid && prj_out_ready`:
  - Pop the tag FIFO.
  - Load `res_bbox` and `res_src`, and set `res_valid`.
- Result with an empty tag FIFO:
  - Set `err`; it stays set until reset.
  - Load the result with `res_src = 0`.
- `inflight` = push count minus pop count, held as a registered counter. Simultaneous push and pop leaves it unchanged.
- Reset mid-operation:
  - Tags, registers and `rr` are cleared.
  - The projector is reset by the same `rst_n`.
  - Stale results arriving after reset set `err`.

## Timing
- Reset values:
  - `req_ready`, `prj_in_valid`, `prj_out_ready`, `res_valid`, `err` = 0. `prj_out_ready` goes to 1 in the first cycle after reset release.
  - `prj_in_box`, `res_bbox`, `res_src`, `inflight`, `rr` = 0.
- Request accept in cycle t → `prj_in_valid` high in cycle t+1.
- Projector result accept in cycle t → `res_valid` high in cycle t+1.
- Total latency = 2 + projector latency.
- Valid/ready rules:
  - Valid never drops and data never changes until accepted.
  - `req_ready` never depends on `req_valid` of a lower-priority requester.
- Sustained throughput is one box per cycle when the projector and downstream do not stall.

## Configuration
- `PROJ_ARB_BOX_CHECK_EN` defined:
  - A granted box with `min_x > max_x`, `min_y > max_y`, `min_z > max_z`, or `max_x <= 0` (box behind the sensor) is accepted but dropped.
  - No tag is pushed and `prj_in_valid` is not raised.
  - Adds output `drop_cnt` [15:0], reset 0, increments per drop and saturates at 0xFFFF.
- Undefined: no check, no `drop_cnt` port, every box is forwarded.

## Structure
- Package `proj_pkg`:
  - `box3d_t` packed struct of six signed 16-bit fields.
  - `bbox2d_t` packed struct of four 16-bit fields.
  - Constant `FRAC_BITS = 9`.
- Sub-module `proj_tag_fifo`: synchronous FIFO of depth `TAG_DEPTH`, width `SRC_W`, with `full`/`empty`/`count`.

## Test plan
- Single requester 0, box `{0x0000,0x0400,0x0C00,0xFC00,0xFC00,0x0800}`, projector model latency 4 → `prj_in_valid` at t+1, `res_valid` at t+6, `res_src = 0`, `inflight` 1 → 0.
- Both requesters valid continuously, 6 boxes each → grants alternate 0,1,0,1…, and `res_src` returns in issue order.
- `prj_in_ready` low for 10 cycles → `prj_in_box` stable, only one `req_ready` pulse, no new grants.
- Projector holds results, `TAG_DEPTH = 8` → exactly 8 issues, then `req_ready` stays 0 and `inflight = 8`. One pop → one further grant one cycle later.
- `prj_out_valid` pulse with `inflight = 0` → `err = 1` persists until `rst_n` low. Assert `rst_n` mid-stream → all outputs return to reset values asynchronously.
- With `PROJ_ARB_BOX_CHECK_EN` defined, box `min_x = 0x0C00`, `max_x = 0x0800` → `req_ready` pulse, no `prj_in_valid`, `drop_cnt = 1`.
